// File: rtl/axi_lite_resp_ctrl_pkg.sv
// Shared bridge definitions: AXI response codes, write FSM states and a
// saturating add used by the error counter.
`timescale 1ns/1ps
package axi_lite_resp_ctrl_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_WAIT   = 2'd1,
    W_COMMIT = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/axi_lite_resp_ctrl_addr_decode.sv
// Combinational address classifier shared by the AW and AR paths.
`timescale 1ns/1ps
module axi_addr_decode #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned N_CH      = 8,
  parameter int unsigned STAT_BASE = 32'h10,
  parameter int unsigned CH_W      = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              data_hit,
  output logic              stat_hit,
  output logic              odd,
  output logic [CH_W-1:0]   ch
);

  localparam logic [ADDR_W-1:0] DATA_END = ADDR_W'(2 * N_CH);
  localparam logic [ADDR_W-1:0] STAT_LO  = ADDR_W'(STAT_BASE);
  localparam logic [ADDR_W-1:0] STAT_HI  = ADDR_W'(STAT_BASE + 2 * N_CH);

  // Data registers win if the status window is ever placed over them.
  always_comb begin
    data_hit = (addr < DATA_END);
    stat_hit = !data_hit && (addr >= STAT_LO) && (addr < STAT_HI);
    odd      = addr[0];
    ch       = addr[CH_W:1];
  end

endmodule

// File: rtl/axi_lite_resp_ctrl.sv
// AXI-Lite response controller: classifies AW/AR addresses, sequences SPI
// data-register commits and keeps a saturating error count.
`timescale 1ns/1ps
module axi_lite_resp_ctrl
  import axi_lite_resp_ctrl_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 8,
  parameter  int unsigned N_CH      = 8,
  parameter  int unsigned STAT_BASE = 32'h10,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              ACLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  input  logic              AWREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  input  logic              ARREADY,
  input  logic              BREADY,
  input  logic [N_CH-1:0]   wr_busy,
  input  logic [N_CH-1:0]   rd_valid,
  input  logic              ssq_full,
  input  logic              wr_update_done,
  output logic [1:0]        bresp,
  output logic              bresp_valid,
  output logic [1:0]        rresp,
  output logic [ADDR_W-1:0] wr_slave_addr,
  output logic [CH_W-1:0]   wr_ch,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_stat_addr,
  output logic [ADDR_W-1:0] rd_stat_addr,
  output logic [7:0]        err_cnt
);

  // state    | meaning
  // W_IDLE   | accepting one AW handshake
  // W_WAIT   | OKAY write held until the data register update completes
  // W_COMMIT | one-cycle wr_en strobe
  // W_RESP   | bresp_valid until BREADY

  wr_state_e         state_q, state_d;
  resp_e             bresp_q, bresp_d;
  resp_e             rresp_q, rresp_d;
  logic [ADDR_W-1:0] wr_slave_addr_q, wr_slave_addr_d;
  logic [CH_W-1:0]   wr_ch_q, wr_ch_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic aw_data_hit, aw_stat_hit, aw_odd;
  logic ar_data_hit, ar_stat_hit, ar_odd;
  logic [CH_W-1:0] aw_ch, ar_ch;
  logic aw_hs, ar_hs, wr_capture, wr_err, rd_err;
  resp_e wr_cls, rd_cls;

  axi_addr_decode #(
    .ADDR_W(ADDR_W), .N_CH(N_CH), .STAT_BASE(STAT_BASE), .CH_W(CH_W)
  ) u_aw_decode (
    .addr(AWADDR), .data_hit(aw_data_hit), .stat_hit(aw_stat_hit),
    .odd(aw_odd), .ch(aw_ch)
  );

  axi_addr_decode #(
    .ADDR_W(ADDR_W), .N_CH(N_CH), .STAT_BASE(STAT_BASE), .CH_W(CH_W)
  ) u_ar_decode (
    .addr(ARADDR), .data_hit(ar_data_hit), .stat_hit(ar_stat_hit),
    .odd(ar_odd), .ch(ar_ch)
  );

  assign aw_hs        = AWVALID & AWREADY;
  assign ar_hs        = ARVALID & ARREADY;
  assign wr_stat_addr = ADDR_W'(STAT_BASE) + ADDR_W'(AWADDR[4:0]);
  assign rd_stat_addr = ADDR_W'(STAT_BASE) + ADDR_W'(ARADDR[4:0]);

  // Status registers are read-only, so a write there decodes as an error.
  always_comb begin
    wr_cls = RESP_OKAY;
    if (aw_stat_hit || !aw_data_hit || aw_odd)
      wr_cls = RESP_DECERR;
    else if (wr_busy[aw_ch] || ssq_full)
      wr_cls = RESP_SLVERR;
  end

  always_comb begin
    rd_cls = RESP_DECERR;
    if (ar_data_hit && ar_odd)
      rd_cls = rd_valid[ar_ch] ? RESP_OKAY : RESP_EXOKAY;
    else if (ar_stat_hit)
      rd_cls = RESP_OKAY;
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) state_q <= W_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:   if (aw_hs) state_d = (wr_cls == RESP_OKAY) ? W_WAIT : W_RESP;
      W_WAIT:   if (wr_update_done) state_d = W_COMMIT;
      W_COMMIT: state_d = W_RESP;
      W_RESP:   if (BREADY) state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase
  end

  // Decoded from state so an async reset drops wr_en immediately.
  always_comb begin
    wr_en       = (state_q == W_COMMIT);
    bresp_valid = (state_q == W_RESP);
  end

  always_comb begin
    wr_capture      = (state_q == W_IDLE) && aw_hs;
    wr_err          = wr_capture && (wr_cls != RESP_OKAY);
    rd_err          = ar_hs && (rd_cls == RESP_DECERR);
    bresp_d         = wr_capture ? wr_cls : bresp_q;
    rresp_d         = ar_hs ? rd_cls : rresp_q;
    wr_slave_addr_d = wr_slave_addr_q;
    wr_ch_d         = wr_ch_q;
    if (wr_capture && (wr_cls == RESP_OKAY)) begin
      wr_slave_addr_d = AWADDR;
      wr_ch_d         = aw_ch;
    end
    err_cnt_d = sat_add8(err_cnt_q, {1'b0, wr_err} + {1'b0, rd_err});
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      bresp_q         <= RESP_OKAY;
      rresp_q         <= RESP_OKAY;
      wr_slave_addr_q <= '0;
      wr_ch_q         <= '0;
      err_cnt_q       <= '0;
    end else begin
      bresp_q         <= bresp_d;
      rresp_q         <= rresp_d;
      wr_slave_addr_q <= wr_slave_addr_d;
      wr_ch_q         <= wr_ch_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  assign bresp         = bresp_q;
  assign rresp         = rresp_q;
  assign wr_slave_addr = wr_slave_addr_q;
  assign wr_ch         = wr_ch_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_resp_ctrl.sv
// Directed plus randomized bench for axi_lite_resp_ctrl against a
// transaction-level address-map / error-count model.
`timescale 1ns/1ps
module tb_axi_lite_resp_ctrl;

  localparam int ADDR_W    = 8;
  localparam int N_CH      = 8;
  localparam int STAT_BASE = 'h10;

  logic ACLK = 1'b0;
  logic reset;
  logic [7:0] AWADDR, ARADDR;
  logic AWVALID, AWREADY, ARVALID, ARREADY, BREADY;
  logic [7:0] wr_busy, rd_valid;
  logic ssq_full, wr_update_done;
  logic [1:0] bresp, rresp;
  logic bresp_valid, wr_en;
  logic [7:0] wr_slave_addr, wr_stat_addr, rd_stat_addr, err_cnt;
  logic [2:0] wr_ch;

  int compared   = 0;
  int mismatched = 0;
  int exp_err    = 0;
  logic [1:0] exp_rresp = 2'b00;
  logic [7:0] exp_waddr = 8'h00;
  logic [2:0] exp_ch    = 3'd0;

  axi_lite_resp_ctrl #(.ADDR_W(ADDR_W), .N_CH(N_CH), .STAT_BASE(STAT_BASE)) dut (
    .ACLK(ACLK), .reset(reset),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .BREADY(BREADY), .wr_busy(wr_busy), .rd_valid(rd_valid),
    .ssq_full(ssq_full), .wr_update_done(wr_update_done),
    .bresp(bresp), .bresp_valid(bresp_valid), .rresp(rresp),
    .wr_slave_addr(wr_slave_addr), .wr_ch(wr_ch), .wr_en(wr_en),
    .wr_stat_addr(wr_stat_addr), .rd_stat_addr(rd_stat_addr),
    .err_cnt(err_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address-map rules expressed directly on integer addresses.
  function automatic logic [1:0] m_wr(input int a, input logic [7:0] busy, input logic full);
    if (a < 2 * N_CH && a % 2 == 0) return (busy[a / 2] || full) ? 2'b10 : 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [1:0] m_rd(input int a, input logic [7:0] rdv);
    if (a < 2 * N_CH && a % 2 == 1) return rdv[a / 2] ? 2'b00 : 2'b01;
    if (a >= STAT_BASE && a < STAT_BASE + 2 * N_CH) return 2'b00;
    return 2'b11;
  endfunction

  task automatic add_err(input int n);
    exp_err = (exp_err + n > 255) ? 255 : exp_err + n;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".bresp"}, bresp, 0);
    chk({tag, ".bresp_valid"}, bresp_valid, 0);
    chk({tag, ".rresp"}, rresp, 0);
    chk({tag, ".wr_slave_addr"}, wr_slave_addr, 0);
    chk({tag, ".wr_ch"}, wr_ch, 0);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".err_cnt"}, err_cnt, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk_reset_vals(tag);
    exp_err = 0; exp_rresp = 2'b00; exp_waddr = 8'h00; exp_ch = 3'd0;
    @(negedge ACLK);
    reset = 1'b0;
    tick();
  endtask

  task automatic do_write(input int a, input logic [7:0] busy, input logic full,
                          input int wait_cyc, input int hold, input bit poke);
    logic [1:0] code;
    AWADDR = 8'(a); wr_busy = busy; ssq_full = full; AWVALID = 1'b1; AWREADY = 1'b1;
    #1 chk("wr_stat_addr", wr_stat_addr, (STAT_BASE + (a & 31)) & 255);
    tick();
    AWVALID = 1'b0;
    code = m_wr(a, busy, full);
    if (code != 2'b00) add_err(1);
    chk("bresp", bresp, code);
    chk("err_cnt_wr", err_cnt, exp_err);
    if (code == 2'b00) begin
      exp_waddr = 8'(a); exp_ch = 3'(a / 2);
      chk("wait_bvalid", bresp_valid, 0);
      for (int i = 0; i < wait_cyc; i++) begin
        if (poke) begin AWVALID = 1'b1; AWADDR = 8'($urandom_range(0, 255)); end
        tick();
        AWVALID = 1'b0;
        chk("wait_wr_en", wr_en, 0);
        chk("wait_addr_held", wr_slave_addr, exp_waddr);
      end
      wr_update_done = 1'b1;
      tick();
      wr_update_done = 1'b0;
      chk("commit_wr_en", wr_en, 1);
      chk("commit_addr", wr_slave_addr, exp_waddr);
      chk("commit_ch", wr_ch, exp_ch);
      chk("commit_bvalid", bresp_valid, 0);
      tick();
    end
    chk("resp_wr_en", wr_en, 0);
    chk("resp_bvalid", bresp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_bvalid", bresp_valid, 1);
    end
    BREADY = 1'b1;
    if (poke) begin AWVALID = 1'b1; AWADDR = 8'($urandom_range(0, 255)); end
    tick();
    BREADY = 1'b0; AWVALID = 1'b0;
    chk("done_bvalid", bresp_valid, 0);
    chk("done_bresp", bresp, code);
    chk("done_err_cnt", err_cnt, exp_err);
    tick();
    chk("idle_bvalid", bresp_valid, 0);
    chk("idle_bresp", bresp, code);
    chk("idle_addr", wr_slave_addr, exp_waddr);
  endtask

  task automatic do_read(input int a, input logic [7:0] rdv);
    ARADDR = 8'(a); rd_valid = rdv; ARVALID = 1'b1; ARREADY = 1'b1;
    #1 chk("rd_stat_addr", rd_stat_addr, (STAT_BASE + (a & 31)) & 255);
    tick();
    ARVALID = 1'b0;
    exp_rresp = m_rd(a, rdv);
    if (exp_rresp == 2'b11) add_err(1);
    chk("rresp", rresp, exp_rresp);
    chk("err_cnt_rd", err_cnt, exp_err);
  endtask

  initial begin
    reset = 1'b1;
    AWADDR = 0; ARADDR = 0; AWVALID = 0; AWREADY = 0; ARVALID = 0; ARREADY = 0;
    BREADY = 0; wr_busy = 0; rd_valid = 0; ssq_full = 0; wr_update_done = 0;
    #12;
    chk_reset_vals("por");
    @(negedge ACLK);
    reset = 1'b0;
    tick();

    // Clean write to channel 2, update two cycles after the handshake.
    do_write('h04, 8'h00, 1'b0, 1, 2, 1'b0);
    // Send queue full.
    do_write('h06, 8'h00, 1'b1, 0, 0, 1'b0);
    chk("slverr_cnt", err_cnt, 1);
    do_reset("rst1");
    // Odd write address then unmapped read.
    do_write('h03, 8'h00, 1'b0, 0, 1, 1'b0);
    do_read('h40, 8'h00);
    chk("decerr_cnt", err_cnt, 2);
    // Read register with and without valid data, and a status read.
    do_read('h05, 8'h00);
    do_read('h05, 8'h04);
    do_read('h1F, 8'h00);
    tick();
    chk("rresp_held", rresp, exp_rresp);
    // Write to a status address is rejected; busy channel gives SLVERR.
    do_write('h10, 8'h00, 1'b0, 0, 0, 1'b0);
    do_write('h0E, 8'h80, 1'b0, 2, 0, 1'b1);

    // Write and read error registered in the same cycle.
    AWADDR = 8'h07; AWVALID = 1'b1; AWREADY = 1'b1;
    ARADDR = 8'h30; ARVALID = 1'b1; ARREADY = 1'b1;
    tick();
    AWVALID = 1'b0; ARVALID = 1'b0;
    add_err(2);
    exp_rresp = 2'b11;
    chk("dual_err_cnt", err_cnt, exp_err);
    chk("dual_bresp", bresp, 3);
    chk("dual_rresp", rresp, 3);
    BREADY = 1'b1; tick(); BREADY = 1'b0;
    chk("dual_bvalid", bresp_valid, 0);

    // Reset while waiting for the update: no stale commit afterwards.
    AWADDR = 8'h04; wr_busy = 0; ssq_full = 0; AWVALID = 1'b1; AWREADY = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    do_reset("rst_wait");
    wr_update_done = 1'b1; tick(); wr_update_done = 1'b0;
    chk("post_rst_wr_en", wr_en, 0);
    tick();
    chk("post_rst_wr_en2", wr_en, 0);
    chk("post_rst_bvalid", bresp_valid, 0);

    // Reset during the commit strobe drops wr_en at once.
    AWADDR = 8'h08; AWVALID = 1'b1; AWREADY = 1'b1;
    tick();
    AWVALID = 1'b0; wr_update_done = 1'b1;
    tick();
    wr_update_done = 1'b0;
    chk("pre_rst_wr_en", wr_en, 1);
    do_reset("rst_commit");
    tick();
    chk("post_commit_rst_wr_en", wr_en, 0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int sel, a;
      sel = int'($urandom_range(0, 3));
      if (sel <= 1) begin
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
        do_write(a, 8'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 1'b1);
      end else if (sel == 2) begin
        do_read(int'($urandom_range(0, 47)), 8'($urandom));
      end else begin
        wr_update_done = 1'b1; ARVALID = 1'b1; ARREADY = 1'b0;
        ARADDR = 8'($urandom_range(0, 255));
        tick();
        wr_update_done = 1'b0; ARVALID = 1'b0;
        chk("idle_done_wr_en", wr_en, 0);
        chk("idle_rresp_held", rresp, exp_rresp);
        chk("idle_err_cnt", err_cnt, exp_err);
      end
    end

    // Drive the counter into saturation.
    for (int n = 0; n < 300; n++) do_read('h40, 8'h00);
    chk("sat_err_cnt", err_cnt, 8'hFF);
    do_write('h01, 8'h00, 1'b0, 0, 0, 1'b0);
    chk("sat_hold", err_cnt, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_lite_resp_ctrl.md
AXI_LITE_RESP_CTRL -- requirements
Module: axi_lite_resp_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 8, AXI address width; N_CH, default 8, number of SPI slave channels (1..16); STAT_BASE, default 8'h10, base address of the status register block.
REQ-002 SHALL have ports (name, direction, width, meaning):
- ACLK, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- AWADDR, in, ADDR_W, write address.
- AWVALID, in, 1, write address valid.
- AWREADY, in, 1, write address ready (observed only).
- ARADDR, in, ADDR_W, read address.
- ARVALID, in, 1, read address valid.
- ARREADY, in, 1, read address ready (observed only).
- BREADY, in, 1, master accepts the write response.
- wr_busy, in, N_CH, per-channel write-register busy.
- rd_valid, in, N_CH, per-channel read data valid.
- ssq_full, in, 1, SPI send queue full.
- wr_update_done, in, 1, data register update complete.
- bresp, out, 2, write response.
- bresp_valid, out, 1, write response valid.
- rresp, out, 2, read response.
- wr_slave_addr, out, ADDR_W, committed write address.
- wr_ch, out, $clog2(N_CH), committed channel index.
- wr_en, out, 1, single-cycle commit strobe.
- wr_stat_addr, out, ADDR_W, status address derived from AWADDR.
- rd_stat_addr, out, ADDR_W, status address derived from ARADDR.
- err_cnt, out, 8, saturating error count.
REQ-003 SHALL clock ACLK and reset reset, asynchronous, active-high.

Function
REQ-004 SHALL decode addresses as follows: write data register of channel c = 2c; read data register of channel c = 2c+1, for c < N_CH; status addresses = STAT_BASE..STAT_BASE+2*N_CH-1 (read only); any other address is unmapped.
REQ-005 SHALL drive wr_stat_addr = STAT_BASE + AWADDR[4:0] and rd_stat_addr = STAT_BASE + ARADDR[4:0], both combinational.
REQ-006 SHALL classify writes: unmapped address or odd address -> DECERR (2'b11); mapped channel with wr_busy[c]=1 or ssq_full=1 -> SLVERR (2'b10); otherwise OKAY (2'b00).
REQ-007 SHALL run a write FSM with states W_IDLE, W_WAIT, W_COMMIT, W_RESP.
- W_IDLE: on AWVALID&AWREADY, register the classification into bresp. OKAY -> latch wr_slave_addr and wr_ch, go to W_WAIT. Error -> go to W_RESP without wr_en.
- W_WAIT: on wr_update_done, go to W_COMMIT.
- W_COMMIT: wr_en=1 for exactly one cycle, then go to W_RESP.
- W_RESP: bresp_valid=1; on BREADY, return to W_IDLE.
REQ-008 SHALL ignore AW handshakes outside W_IDLE, with no state change; only one write is outstanding at a time.
REQ-009 SHALL ignore wr_update_done outside W_WAIT.
REQ-010 SHALL register rresp one cycle after ARVALID&ARREADY and hold it until the next AR handshake:
- read data c with rd_valid[c]=1 -> OKAY;
- read data c with rd_valid[c]=0 -> EXOKAY (2'b01);
- status address -> OKAY;
- otherwise -> DECERR.
REQ-011 SHALL increment err_cnt by one for each registered DECERR/SLVERR bresp and each DECERR rresp, and saturate at 8'hFF.
REQ-012 SHALL add 2 to err_cnt, saturating at 8'hFF, when a write error and a read error are registered in the same cycle.
REQ-013 SHALL treat bresp_valid&BREADY in W_RESP coinciding with a new AW handshake as returning to W_IDLE only; the new address is not captured.

Reset
REQ-014 SHALL on reset assert, at any time including mid-transaction, force:
- FSM to W_IDLE;
- bresp=2'b00, bresp_valid=0, rresp=2'b00;
- wr_slave_addr=0, wr_ch=0, wr_en=0, err_cnt=0.
REQ-015 SHALL on reset drop wr_en in the same cycle if it is asserted, and produce no pending commit after reset release.

Structure
REQ-016 SHALL take the response codes (OKAY, EXOKAY, SLVERR, DECERR) and the FSM state encodings from the shared bridge package.
REQ-017 SHALL implement address classification in one combinational sub-module, axi_addr_decode, instantiated once for AW and once for AR.

Verification
REQ-018 Bench SHALL cover: AWADDR=8'h04, wr_busy=0, ssq_full=0, AW handshake, wr_update_done two cycles later -> wr_en pulses one cycle with wr_slave_addr=8'h04 and wr_ch=2; then bresp=00 and bresp_valid=1 until BREADY.
REQ-019 Bench SHALL cover: AWADDR=8'h06 with ssq_full=1 -> bresp=10, no wr_en, err_cnt 0->1.
REQ-020 Bench SHALL cover: AWADDR=8'h03 (odd) -> bresp=11; then ARADDR=8'h40 -> rresp=11 one cycle after the AR handshake, err_cnt=2.
REQ-021 Bench SHALL cover: ARADDR=8'h05 with rd_valid[2]=0 -> rresp=01; with rd_valid[2]=1 -> rresp=00; ARADDR=8'h1F -> rresp=00.
REQ-022 Bench SHALL cover: reset asserted in W_WAIT -> all outputs at reset values immediately; a later wr_update_done produces no wr_en.
REQ-023 Bench SHALL cover: 300 forced decode errors -> err_cnt holds 8'hFF.
